fix_field_scheduler: RTL and testbench
======================================

Name: fix_field_scheduler

Overview:
- Sequences FIX tag/value fields into the message-create byte engine (fsm_msg_create_2-style interface: tag/val valid strobes, thermometer size masks, done/end returns).
- Accepts one field at a time from the upstream message builder over a valid/ready handshake.
- Presents the tag, then the value, to the engine. After the last field it appends the checksum trailer (tag "10") and reports message completion.
- Adds length checking, a stall watchdog, and per-message field counting.

Parameters:
- VALUE_WIDTH, `VALUE_DATA_WIDTH: value bus width in bits; maximum value length VMAX = VALUE_WIDTH/8 bytes.
- T_SIZE, 5: width of the tag thermometer size mask.
- SIZE, 64: width of the value thermometer size mask; must be >= VMAX.
- LEN_W, 7: width of the value byte-count input.
- TIMEOUT_CYC, 1024: maximum cycles spent in any wait state before abort.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- fld_valid_i  in  1  upstream field valid
- fld_ready_o  out  1  scheduler can accept a field
- fld_tag_i  in  32  tag ASCII bytes, byte 0 (bits 7:0) sent first
- fld_tag_len_i  in  3  tag byte count
- fld_val_i  in  VALUE_WIDTH  value ASCII bytes, byte 0 sent first
- fld_val_len_i  in  LEN_W  value byte count
- fld_last_i  in  1  field is the last body field of the message
- tag_valid_o  out  1  tag start strobe to engine
- val_valid_o  out  1  value start strobe to engine
- checksum_o  out  1  current tag is the checksum trailer
- tag_o  out  32  tag bytes to engine
- val_o  out  VALUE_WIDTH  value bytes to engine
- t_size_o  out  T_SIZE  tag length as thermometer mask
- v_size_o  out  SIZE  value length as thermometer mask
- done_i  in  1  engine finished tag ('=' emitted) or value (SOH emitted)
- end_i  in  1  engine finished checksum trailer
- busy_o  out  1  not in IDLE
- msg_done_o  out  1  one-cycle pulse, message complete
- field_cnt_o  out  8  body fields sent in the current message
- err_len_o  out  1  one-cycle pulse, field dropped for bad length
- err_timeout_o  out  1  sticky; watchdog expired

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, except fld_ready_o=1. Holding registers, field_cnt and watchdog are cleared. err_timeout_o is cleared only by reset.
- Thermometer encoding: mask = (1<<n)-1.
  - Tag: n = fld_tag_len_i.
  - Value: n = fld_val_len_i.
  - Examples: 2 bytes -> 5'b00011; 3 bytes -> 64'h7.
- Length validity:
  - Tag length must be in 1..4.
  - Value length must be in 1..VMAX.
- States and transitions:
  - IDLE: fld_ready_o=1. Fields are accepted on fld_valid_i & fld_ready_o, latching tag, value, masks and last flag.
    - Valid lengths -> TAG.
    - Invalid lengths -> err_len_o pulse and field dropped. If last, go to CHK; else stay in IDLE.
  - TAG: tag_valid_o=1 for exactly one cycle, checksum_o=0 -> TAG_W.
  - TAG_W: wait for done_i -> VAL.
  - VAL: val_valid_o=1 for exactly one cycle -> VAL_W.
  - VAL_W: wait for done_i, then increment field_cnt_o (saturates at 255). If last -> CHK; else -> IDLE.
  - CHK: tag_o=32'h0000_3031 ("1" then "0"), t_size_o=5'b00011, checksum_o=1, tag_valid_o=1 for one cycle -> CHK_W.
  - CHK_W: ignore done_i; wait for end_i. Then msg_done_o pulse, field_cnt_o cleared next cycle -> IDLE.
- tag_o, val_o, t_size_o, v_size_o and checksum_o are registered and held stable from TAG/CHK until the next field is latched. The engine indexes them every cycle.
- fld_ready_o is 0 in every state except IDLE, so only one field is in flight.
- Watchdog:
  - Counts cycles in TAG_W, VAL_W and CHK_W, and resets on entry to each state.
  - At TIMEOUT_CYC: set err_timeout_o, clear field_cnt_o, go to IDLE without msg_done_o. All strobes deasserted.
- Simultaneous events:
  - done_i in the cycle of entering TAG_W is honoured.
  - end_i outside CHK_W is ignored.
  - done_i outside TAG_W/VAL_W is ignored.
- Reset mid-message aborts immediately; no trailer is sent.

Test Plan:
- Single-field message: tag "35" (32'h3533, len 2), value "D" (len 1), last=1; engine model returns done after 3 cycles each, end 5 cycles after CHK. Required:
  - tag_valid pulses with t_size=00011, then val_valid with v_size=1, then tag_valid with checksum_o=1 and tag 0x3031.
  - msg_done_o pulses once; field_cnt_o=1 before the clear.
- Three fields (last only on the third): field_cnt_o steps 1,2,3; exactly one checksum trailer after field 3; fld_ready_o=0 throughout each field.
- Bad length: tag_len=0, then val_len=VMAX+1 with last=1. Required: two err_len_o pulses, no val_valid for either field, the checksum trailer still issued.
- Watchdog: engine never asserts done_i after TAG. Required: err_timeout_o=1 exactly TIMEOUT_CYC cycles after entering TAG_W; state IDLE; no msg_done_o; err_timeout_o stays 1 until reset.
- Reset asserted during VAL_W: all outputs return to reset values asynchronously; the next accepted field starts cleanly with field_cnt_o=0.
- Spurious end_i in IDLE and done_i in CHK_W: no state change, no msg_done_o until end_i arrives in CHK_W.

Source files
------------

// File: rtl/fix_field_scheduler.sv
// fix_field_scheduler: feeds FIX tag/value fields one at a time into the
// message-create byte engine and closes each message with the "10" trailer.
`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 64
`endif

module fix_field_scheduler #(
    parameter int VALUE_WIDTH = `VALUE_DATA_WIDTH,
    parameter int T_SIZE      = 5,
    parameter int SIZE        = 64,
    parameter int LEN_W       = 7,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fld_valid_i,
    output logic                   fld_ready_o,
    input  logic [31:0]            fld_tag_i,
    input  logic [2:0]             fld_tag_len_i,
    input  logic [VALUE_WIDTH-1:0] fld_val_i,
    input  logic [LEN_W-1:0]       fld_val_len_i,
    input  logic                   fld_last_i,
    output logic                   tag_valid_o,
    output logic                   val_valid_o,
    output logic                   checksum_o,
    output logic [31:0]            tag_o,
    output logic [VALUE_WIDTH-1:0] val_o,
    output logic [T_SIZE-1:0]      t_size_o,
    output logic [SIZE-1:0]        v_size_o,
    input  logic                   done_i,
    input  logic                   end_i,
    output logic                   busy_o,
    output logic                   msg_done_o,
    output logic [7:0]             field_cnt_o,
    output logic                   err_len_o,
    output logic                   err_timeout_o
);

    localparam int VMAX = VALUE_WIDTH / 8;
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_TAG_W,
        S_VAL,
        S_VAL_W,
        S_CHK,
        S_CHK_W
    } state_t;

    state_t state_q, state_d;

    logic [WD_W-1:0]        wd_q;
    logic [7:0]             cnt_q;
    logic                   last_q;
    logic                   err_to_q;
    logic [31:0]            tag_q;
    logic [VALUE_WIDTH-1:0] val_q;
    logic [T_SIZE-1:0]      tsz_q;
    logic [SIZE-1:0]        vsz_q;
    logic                   chk_q;

    logic                   len_ok;
    logic                   wd_exp;
    logic                   accept;
    logic                   cnt_inc;
    logic                   cnt_clr;
    logic                   set_to;
    logic                   load_chk;
    logic [T_SIZE-1:0]      tsz_d;
    logic [SIZE-1:0]        vsz_d;

    assign len_ok = (fld_tag_len_i != 3'd0) && (fld_tag_len_i <= 3'd4) &&
                    (fld_val_len_i != '0) &&
                    (int'(fld_val_len_i) <= VMAX);

    assign wd_exp   = (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign load_chk = (state_d == S_CHK) && (state_q != S_CHK);

    // Byte count -> thermometer mask, one bit per byte the engine emits
    always_comb begin
        tsz_d = '0;
        vsz_d = '0;
        for (int i = 0; i < T_SIZE; i++) begin
            tsz_d[i] = (i < int'(fld_tag_len_i));
        end
        for (int i = 0; i < SIZE; i++) begin
            vsz_d[i] = (i < int'(fld_val_len_i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;
        set_to      = 1'b0;
        fld_ready_o = 1'b0;
        tag_valid_o = 1'b0;
        val_valid_o = 1'b0;
        msg_done_o  = 1'b0;
        err_len_o   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                fld_ready_o = 1'b1;
                if (fld_valid_i) begin
                    accept = 1'b1;
                    if (len_ok) begin
                        state_d = S_TAG;
                    end else begin
                        err_len_o = 1'b1;
                        if (fld_last_i) state_d = S_CHK;
                    end
                end
            end
            S_TAG: begin
                tag_valid_o = 1'b1;
                state_d     = S_TAG_W;
            end
            S_TAG_W: begin
                if (done_i) begin
                    state_d = S_VAL;
                end else if (wd_exp) begin
                    set_to  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_VAL: begin
                val_valid_o = 1'b1;
                state_d     = S_VAL_W;
            end
            S_VAL_W: begin
                if (done_i) begin
                    cnt_inc = 1'b1;
                    state_d = last_q ? S_CHK : S_IDLE;
                end else if (wd_exp) begin
                    set_to  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CHK: begin
                tag_valid_o = 1'b1;
                state_d     = S_CHK_W;
            end
            S_CHK_W: begin
                if (end_i) begin
                    msg_done_o = 1'b1;
                    cnt_clr    = 1'b1;
                    state_d    = S_IDLE;
                end else if (wd_exp) begin
                    set_to  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Engine-facing registers; the trailer load overrides a dropped last field
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q  <= '0;
            val_q  <= '0;
            tsz_q  <= '0;
            vsz_q  <= '0;
            chk_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            if (accept) begin
                tag_q  <= fld_tag_i;
                val_q  <= fld_val_i;
                tsz_q  <= tsz_d;
                vsz_q  <= vsz_d;
                chk_q  <= 1'b0;
                last_q <= fld_last_i;
            end
            if (load_chk) begin
                tag_q <= 32'h0000_3031;
                tsz_q <= T_SIZE'(2'b11);
                chk_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            err_to_q <= 1'b0;
            wd_q     <= '0;
        end else begin
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc && (cnt_q != 8'hff)) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (set_to) err_to_q <= 1'b1;
            if (state_d != state_q) begin
                wd_q <= '0;
            end else if (state_q inside {S_TAG_W, S_VAL_W, S_CHK_W}) begin
                wd_q <= wd_q + 1'b1;
            end
        end
    end

    assign tag_o         = tag_q;
    assign val_o         = val_q;
    assign t_size_o      = tsz_q;
    assign v_size_o      = vsz_q;
    assign checksum_o    = chk_q;
    assign busy_o        = (state_q != S_IDLE);
    assign field_cnt_o   = cnt_q;
    assign err_timeout_o = err_to_q;

endmodule

// File: tb/tb_fix_field_scheduler.sv
// tb_fix_field_scheduler: directed fields against an event-queue model
// of the expected engine traffic, with a small engine responder.
`timescale 1ns/1ps

module tb_fix_field_scheduler;

    localparam int VW   = 64;
    localparam int TS   = 5;
    localparam int SZ   = 64;
    localparam int LW   = 7;
    localparam int TO   = 1024;
    localparam int VMAX = VW / 8;

    localparam int K_TAG  = 0;
    localparam int K_VAL  = 1;
    localparam int K_CHK  = 2;
    localparam int K_DONE = 3;
    localparam int K_ERR  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fld_valid_i = 1'b0;
    logic          fld_ready_o;
    logic [31:0]   fld_tag_i = '0;
    logic [2:0]    fld_tag_len_i = '0;
    logic [VW-1:0] fld_val_i = '0;
    logic [LW-1:0] fld_val_len_i = '0;
    logic          fld_last_i = 1'b0;
    logic          tag_valid_o;
    logic          val_valid_o;
    logic          checksum_o;
    logic [31:0]   tag_o;
    logic [VW-1:0] val_o;
    logic [TS-1:0] t_size_o;
    logic [SZ-1:0] v_size_o;
    logic          done_i = 1'b0;
    logic          end_i = 1'b0;
    logic          busy_o;
    logic          msg_done_o;
    logic [7:0]    field_cnt_o;
    logic          err_len_o;
    logic          err_timeout_o;

    fix_field_scheduler #(
        .VALUE_WIDTH(VW), .T_SIZE(TS), .SIZE(SZ),
        .LEN_W(LW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .fld_valid_i(fld_valid_i), .fld_ready_o(fld_ready_o),
        .fld_tag_i(fld_tag_i), .fld_tag_len_i(fld_tag_len_i),
        .fld_val_i(fld_val_i), .fld_val_len_i(fld_val_len_i),
        .fld_last_i(fld_last_i),
        .tag_valid_o(tag_valid_o), .val_valid_o(val_valid_o),
        .checksum_o(checksum_o), .tag_o(tag_o), .val_o(val_o),
        .t_size_o(t_size_o), .v_size_o(v_size_o),
        .done_i(done_i), .end_i(end_i), .busy_o(busy_o),
        .msg_done_o(msg_done_o), .field_cnt_o(field_cnt_o),
        .err_len_o(err_len_o), .err_timeout_o(err_timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] tag;
        logic [4:0]  tsz;
        logic [63:0] val;
        logic [63:0] vsz;
        int          cnt;
    } ev_t;

    ev_t expq[$];
    ev_t e;
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  mcnt = 0;
    bit  mute = 0;
    bit  mute_val = 0;
    bit  spur_end = 0;
    int  dcnt = -1;
    int  scnt = -1;
    int  ecnt = -1;
    int  k;

    logic [4:0]  cap_tsz;
    logic [63:0] cap_vsz;
    logic [31:0] cap_chk_tag;
    int          cap_done_cnt;
    int          tag_cyc;
    int          n_done = 0;
    int          n_err = 0;
    int          n_chk = 0;
    int          n_valv = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Engine: done 3 cycles after a strobe; trailer gets a stray done then end
    always begin
        @(posedge clk);
        #1;
        done_i = 1'b0;
        end_i  = spur_end;
        if (!rst) begin
            dcnt = -1;
            scnt = -1;
            ecnt = -1;
        end else begin
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin done_i = 1'b1; dcnt = -1; end
            end
            if (scnt > 0) begin
                scnt--;
                if (scnt == 0) begin done_i = 1'b1; scnt = -1; end
            end
            if (ecnt > 0) begin
                ecnt--;
                if (ecnt == 0) begin end_i = 1'b1; ecnt = -1; end
            end
            if (!mute && tag_valid_o && checksum_o) begin
                ecnt = 5;
                scnt = 2;
            end else if (!mute && tag_valid_o) begin
                dcnt = 3;
            end else if (!mute && !mute_val && val_valid_o) begin
                dcnt = 3;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (dcnt > 0 || ecnt > 0) check("ready_low_inflight", 64'(fld_ready_o), 0);
            if (tag_valid_o || val_valid_o || err_len_o || msg_done_o) begin
                k = tag_valid_o ? (checksum_o ? K_CHK : K_TAG) :
                    val_valid_o ? K_VAL : err_len_o ? K_ERR : K_DONE;
                check("strobe_onehot",
                      64'($countones({tag_valid_o, val_valid_o, err_len_o, msg_done_o})), 1);
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got kind %0d expected none", k);
                end else begin
                    e = expq.pop_front();
                    check("event_kind", 64'(k), 64'(e.kind));
                    if (k == e.kind) begin
                        case (k)
                            K_TAG, K_CHK: begin
                                check("tag_o", 64'(tag_o), 64'(e.tag));
                                check("t_size_o", 64'(t_size_o), 64'(e.tsz));
                                check("cnt_at_tag", 64'(field_cnt_o), 64'(e.cnt));
                                if (k == K_TAG) begin
                                    cap_tsz = t_size_o;
                                    tag_cyc = cyc;
                                end else begin
                                    cap_chk_tag = tag_o;
                                    n_chk++;
                                end
                            end
                            K_VAL: begin
                                check("val_o", val_o, e.val);
                                check("v_size_o", v_size_o, e.vsz);
                                check("cnt_at_val", 64'(field_cnt_o), 64'(e.cnt));
                                cap_vsz = v_size_o;
                                n_valv++;
                            end
                            K_DONE: begin
                                check("cnt_at_done", 64'(field_cnt_o), 64'(e.cnt));
                                check("done_with_end", 64'(end_i), 1);
                                cap_done_cnt = int'(field_cnt_o);
                                n_done++;
                            end
                            default: n_err++;
                        endcase
                    end
                end
            end
        end
    end

    function automatic logic [63:0] therm(int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    task automatic push(int kind, logic [31:0] t, logic [63:0] ts,
                        logic [63:0] v, logic [63:0] vs, int c);
        ev_t x;
        x.kind = kind;
        x.tag  = t;
        x.tsz  = ts[4:0];
        x.val  = v;
        x.vsz  = vs;
        x.cnt  = c;
        expq.push_back(x);
    endtask

    task automatic send(logic [31:0] tag, int tl, logic [63:0] val, int vl, bit last);
        bit ok;
        int n;
        ok = (tl >= 1 && tl <= 4 && vl >= 1 && vl <= VMAX);
        if (ok) begin
            push(K_TAG, tag, therm(tl), 0, 0, mcnt);
            if (!mute) push(K_VAL, 0, 0, val, therm(vl), mcnt);
            if (!mute && !mute_val) mcnt++;
        end else begin
            push(K_ERR, 0, 0, 0, 0, 0);
        end
        if (last && !mute && !mute_val) begin
            push(K_CHK, 32'h3031, 64'h3, 0, 0, mcnt);
            push(K_DONE, 0, 0, 0, 0, mcnt);
            mcnt = 0;
        end
        fld_tag_i     = tag;
        fld_tag_len_i = 3'(tl);
        fld_val_i     = val;
        fld_val_len_i = LW'(vl);
        fld_last_i    = last;
        fld_valid_i   = 1'b1;
        n = 0;
        while (!fld_ready_o && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("ready_before_accept", 64'(fld_ready_o), 1);
        @(posedge clk);
        #2;
        fld_valid_i = 1'b0;
        fld_last_i  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_o || dcnt > 0 || scnt > 0 || ecnt > 0) && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("reach_idle", 64'(busy_o), 0);
    endtask

    task automatic check_reset_outs(string tag);
        check({tag, "_ready"}, 64'(fld_ready_o), 1);
        check({tag, "_ctl"}, 64'({tag_valid_o, val_valid_o, checksum_o, busy_o,
                                  msg_done_o, err_len_o, err_timeout_o, field_cnt_o}), 0);
        check({tag, "_tag"}, 64'({tag_o, t_size_o}), 0);
        check({tag, "_val"}, val_o, 0);
        check({tag, "_vsz"}, v_size_o, 0);
    endtask

    initial begin
        int n;
        int ref_done;
        int ref_valv;
        int ref_chk;
        int err_cyc;

        repeat (3) @(posedge clk);
        #2;
        check_reset_outs("reset");
        rst = 1'b1;
        @(posedge clk);
        #2;

        // Single field "35"="D", last
        send(32'h0000_3533, 2, 64'h44, 1, 1);
        wait_idle();
        check("single_tsz", 64'(cap_tsz), 64'h03);
        check("single_vsz", cap_vsz, 64'h1);
        check("single_chk_tag", 64'(cap_chk_tag), 64'h3031);
        check("single_done_cnt", 64'(cap_done_cnt), 1);
        check("single_n_done", 64'(n_done), 1);
        check("single_cnt_clear", 64'(field_cnt_o), 0);

        // Three fields, length boundaries on tag (4) and value (VMAX)
        ref_chk = n_chk;
        send(32'h3433_3231, 4, 64'h4241, 2, 0);
        wait_idle();
        check("three_cnt1", 64'(field_cnt_o), 1);
        send(32'h0033_3535, 3, 64'h3837_3635_3433_3231, VMAX, 0);
        wait_idle();
        check("three_cnt2", 64'(field_cnt_o), 2);
        send(32'h0000_3635, 2, 64'h5a, 1, 1);
        wait_idle();
        check("three_done_cnt", 64'(cap_done_cnt), 3);
        check("three_one_trailer", 64'(n_chk - ref_chk), 1);

        // Bad lengths: tag_len 0, then val_len VMAX+1 as last
        ref_valv = n_valv;
        ref_chk  = n_chk;
        send(32'h0000_3535, 0, 64'h41, 1, 0);
        wait_idle();
        send(32'h0000_3535, 2, 64'h41, VMAX + 1, 1);
        wait_idle();
        check("bad_err_pulses", 64'(n_err), 2);
        check("bad_no_val", 64'(n_valv - ref_valv), 0);
        check("bad_trailer", 64'(n_chk - ref_chk), 1);
        check("bad_done_cnt", 64'(cap_done_cnt), 0);

        // Spurious end_i while idle
        ref_done = n_done;
        spur_end = 1'b1;
        @(posedge clk);
        #2;
        spur_end = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("spur_end_busy", 64'(busy_o), 0);
        check("spur_end_no_done", 64'(n_done - ref_done), 0);

        // Watchdog: one good field, then engine goes silent after TAG
        send(32'h0000_3834, 2, 64'h31, 1, 0);
        wait_idle();
        mute = 1'b1;
        ref_done = n_done;
        send(32'h0000_3834, 2, 64'h32, 1, 1);
        n = 0;
        while (!err_timeout_o && n < TO + 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        err_cyc = cyc;
        check("wd_set", 64'(err_timeout_o), 1);
        check("wd_latency", 64'(err_cyc - tag_cyc), 64'(TO + 1));
        check("wd_idle", 64'(busy_o), 0);
        check("wd_cnt_clr", 64'(field_cnt_o), 0);
        check("wd_no_done", 64'(n_done - ref_done), 0);
        mute = 1'b0;
        mcnt = 0;
        send(32'h0000_3533, 2, 64'h44, 1, 1);
        wait_idle();
        check("wd_sticky", 64'(err_timeout_o), 1);

        // Reset while waiting in VAL_W
        send(32'h0000_3533, 2, 64'h41, 1, 0);
        wait_idle();
        mute_val = 1'b1;
        ref_valv = n_valv;
        send(32'h0000_3533, 2, 64'h42, 1, 1);
        n = 0;
        while (n_valv == ref_valv && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        @(posedge clk);
        #2;
        check("pre_rst_busy", 64'(busy_o), 1);
        check("pre_rst_cnt", 64'(field_cnt_o), 1);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outs("async_rst");
        expq.delete();
        mcnt = 0;
        mute_val = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        send(32'h0000_3533, 2, 64'h43, 1, 1);
        wait_idle();
        check("post_rst_done_cnt", 64'(cap_done_cnt), 1);

        check("queue_drained", 64'(expq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
